// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Brief    : Key-driven operand/operator/execute sequencer for the grid
//            calculator; drives an external ALU and selects the display value.
// Revision : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4 * DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [4:0]       key_val,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] display_value,
  output logic             result_valid,
  output logic [2:0]       state
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DIGITS);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  localparam logic [4:0] C_KEY_EXE = 5'h13;
  localparam logic [4:0] C_KEY_CE  = 5'h16;
  localparam logic [4:0] C_KEY_CLR = 5'h17;

  typedef enum logic [2:0] {
    ST_A    = 3'd0,
    ST_B    = 3'd1,
    ST_EXEC = 3'd2,
    ST_RES  = 3'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             is_digit, is_op, cnt_room;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] a_shift, b_shift, digit_ext;

  // Key decode: digit class, operator class and operator-to-ALU encoding.
  always_comb begin
    is_digit  = (key_val[4] == 1'b0);
    is_op     = 1'b1;
    op_code   = 3'd0;
    case (key_val)
      5'h10:   op_code = 3'd0;  // ADD
      5'h14:   op_code = 3'd1;  // SUB
      5'h11:   op_code = 3'd2;  // MULT
      5'h12:   op_code = 3'd3;  // AND
      5'h15:   op_code = 3'd4;  // OR
      default: is_op   = 1'b0;
    endcase
    cnt_room  = (cnt_q < C_CNT_MAX);
    a_shift   = {a_q[WIDTH-5:0], key_val[3:0]};
    b_shift   = {b_q[WIDTH-5:0], key_val[3:0]};
    digit_ext = {{(WIDTH-4){1'b0}}, key_val[3:0]};
  end

  // Next-state and register-update logic for the entry/execute cycle.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    if (state_q == ST_EXEC) begin
      // Single capture cycle; any key arriving now is dropped, CLR included.
      result_d = alu_result;
      state_d  = ST_RES;
    end else if (key_valid) begin
      if (key_val == C_KEY_CLR) begin
        a_d      = '0;
        b_d      = '0;
        result_d = '0;
        op_d     = 3'd0;
        cnt_d    = '0;
        state_d  = ST_A;
      end else begin
        case (state_q)
          ST_A: begin
            if (is_digit) begin
              if (cnt_room) begin
                a_d   = a_shift;
                cnt_d = cnt_q + C_CNT_ONE;
              end
            end else if (is_op) begin
              op_d    = op_code;
              b_d     = '0;
              cnt_d   = '0;
              state_d = ST_B;
            end else if (key_val == C_KEY_CE) begin
              a_d   = '0;
              cnt_d = '0;
            end
          end
          ST_B: begin
            if (is_digit) begin
              if (cnt_room) begin
                b_d   = b_shift;
                cnt_d = cnt_q + C_CNT_ONE;
              end
            end else if (is_op) begin
              op_d = op_code;
            end else if (key_val == C_KEY_EXE) begin
              state_d = ST_EXEC;
            end else if (key_val == C_KEY_CE) begin
              b_d   = '0;
              cnt_d = '0;
            end
          end
          ST_RES: begin
            if (is_digit) begin
              a_d     = digit_ext;
              cnt_d   = C_CNT_ONE;
              state_d = ST_A;
            end else if (is_op) begin
              // Chain: the previous result becomes the new left operand.
              a_d     = result_q;
              op_d    = op_code;
              b_d     = '0;
              cnt_d   = '0;
              state_d = ST_B;
            end else if (key_val == C_KEY_EXE) begin
              // Repeat last operation with the result as the new left operand.
              a_d     = result_q;
              state_d = ST_EXEC;
            end else if (key_val == C_KEY_CE) begin
              a_d     = '0;
              cnt_d   = '0;
              state_d = ST_A;
            end
          end
          default: state_d = ST_A;
        endcase
      end
    end
  end

  // State and datapath registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_A;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      op_q     <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  // Display selection and direct register outputs.
  always_comb begin
    display_value = a_q;
    case (state_q)
      ST_A:    display_value = a_q;
      ST_B:    display_value = (cnt_q != '0) ? b_q : a_q;
      ST_EXEC: display_value = b_q;
      ST_RES:  display_value = result_q;
      default: display_value = a_q;
    endcase
    operand_a    = a_q;
    operand_b    = b_q;
    alu_op       = op_q;
    result_valid = (state_q == ST_RES);
    state        = state_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Brief    : Self-checking bench for calc_sequencer with an ALU model and a
//            result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 16;

  localparam logic [4:0] K_ADD = 5'h10, K_MULT = 5'h11, K_AND = 5'h12,
                         K_EXE = 5'h13, K_SUB = 5'h14, K_OR = 5'h15,
                         K_CE = 5'h16, K_CLR = 5'h17;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             key_valid = 1'b0;
  logic [4:0]       key_val = 5'h0;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] operand_a, operand_b, display_value;
  logic [2:0]       alu_op, state;
  logic             result_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic rv_prev = 1'b0;

  calc_sequencer #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_val(key_val),
    .alu_result(alu_result), .operand_a(operand_a), .operand_b(operand_b),
    .alu_op(alu_op), .display_value(display_value),
    .result_valid(result_valid), .state(state)
  );

  always #5 clk = ~clk;

  // External ALU model.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = operand_a + operand_b;
      3'd1:    alu_result = operand_a - operand_b;
      3'd2:    alu_result = WIDTH'(operand_a * operand_b);
      3'd3:    alu_result = operand_a & operand_b;
      3'd4:    alu_result = operand_a | operand_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: each rising result_valid pops one expected result.
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      if (sb_q.size() == 0) check("sb_unexpected_result", 32'd1, 32'd0);
      else check("sb_result", 32'(display_value), 32'(sb_q.pop_front()));
    end
    rv_prev = result_valid;
  end

  task automatic key(input logic [4:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_val   = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic keys(input logic [4:0] seq[$]);
    foreach (seq[i]) key(seq[i]);
  endtask

  // EXE from B/RES with latency checks; expected result goes on the scoreboard.
  task automatic press_exe(input logic [WIDTH-1:0] exp);
    @(negedge clk);
    key_valid = 1'b1;
    key_val   = K_EXE;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("exe_state_exec", 32'(state), 32'd2);
    check("exe_rv_low", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    check("exe_rv_high", 32'(result_valid), 32'd1);
    check("exe_state_res", 32'(state), 32'd3);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 32'(operand_a), 32'd0);
    check({tag, "_b"}, 32'(operand_b), 32'd0);
    check({tag, "_op"}, 32'(alu_op), 32'd0);
    check({tag, "_disp"}, 32'(display_value), 32'd0);
    check({tag, "_rv"}, 32'(result_valid), 32'd0);
    check({tag, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1,2,ADD,3,EXE
    keys('{5'h1, 5'h2, K_ADD});
    check("b_disp_cnt0", 32'(display_value), 32'h12);
    check("b_state", 32'(state), 32'd1);
    key(5'h3);
    check("s1_a", 32'(operand_a), 32'h12);
    check("s1_b", 32'(operand_b), 32'h3);
    check("s1_op", 32'(alu_op), 32'd0);
    check("b_disp_cnt1", 32'(display_value), 32'h3);
    press_exe(16'h0015);
    check("s1_disp", 32'(display_value), 32'h15);

    // Chaining: SUB,5,EXE then repeat EXE
    keys('{K_SUB, 5'h5});
    check("s3_a", 32'(operand_a), 32'h15);
    check("s3_op", 32'(alu_op), 32'd1);
    press_exe(16'h0010);
    check("s3_res", 32'(display_value), 32'h10);
    press_exe(16'h000B);
    check("s3r_a", 32'(operand_a), 32'h10);
    check("s3r_b", 32'(operand_b), 32'h5);
    check("s3r_res", 32'(display_value), 32'hB);

    // Digit in RES restarts A; fifth digit dropped; invalid/EXE ignored in A
    keys('{5'h1, 5'h2, 5'h3, 5'h4, 5'h5});
    check("s2_a", 32'(operand_a), 32'h1234);
    check("s2_disp", 32'(display_value), 32'h1234);
    check("s2_state", 32'(state), 32'd0);
    keys('{5'h1A, K_EXE});
    check("inv_a", 32'(operand_a), 32'h1234);
    check("inv_state", 32'(state), 32'd0);

    // 7,MULT,9,CE,2,EXE then CLR
    keys('{K_CLR, 5'h7, K_MULT, 5'h9, K_CE, 5'h2});
    check("s4_b", 32'(operand_b), 32'h2);
    check("s4_op", 32'(alu_op), 32'd2);
    press_exe(16'h000E);
    key(K_CLR);
    check_zero("clr");

    // A,OR,B,EXE followed immediately by CLR during EXEC
    keys('{5'hA, K_OR, 5'hB});
    @(negedge clk);
    key_valid = 1'b1;
    key_val   = K_EXE;
    sb_q.push_back(16'h000B);
    @(negedge clk);
    key_val   = K_CLR;
    @(negedge clk);
    key_valid = 1'b0;
    check("s5_state", 32'(state), 32'd3);
    check("s5_rv", 32'(result_valid), 32'd1);
    check("s5_disp", 32'(display_value), 32'hB);
    check("s5_a", 32'(operand_a), 32'hA);

    // Asynchronous reset in the middle of EXEC
    keys('{K_CLR, 5'h1, K_ADD, 5'h2});
    @(negedge clk);
    key_valid = 1'b1;
    key_val   = K_EXE;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("rst_pre_exec", 32'(state), 32'd2);
    #2 rst = 1'b0;
    #1;
    check_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    key(5'h3);
    check("post_rst_a", 32'(operand_a), 32'h3);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
